run_ctrl: RTL and testbench
===========================

Name: run_ctrl

Overview:
- Parametrised run controller that wraps the CPU core and replaces the bare req/done (done = Halt) handshake.
- Holds the core in reset between runs and loads a per-program start PC from a configurable table.
- Measures run length in cycles, enforces an optional watchdog timeout, and queues one request that arrives during a run.
- Sits between the testbench/host and the core's PC and reset inputs.

Parameters:
- D, 10, PC width; matches the core PC.
- NPROG, 4, number of program slots (≥2).
- PW, $clog2(NPROG), width of the program-select field.
- CW, 16, cycle-counter and timeout width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  run request, sampled every cycle.
- prog_sel  in  PW  program slot for req.
- tmo_limit  in  CW  watchdog limit; 0 disables the watchdog.
- cfg_we  in  1  start-table write enable.
- cfg_idx  in  PW  start-table write index.
- cfg_addr  in  D  start-table write data.
- halt  in  1  core Halt decode.
- core_rst  out  1  active-high hold-reset to the core.
- pc_load  out  1  one-cycle strobe loading start_pc into the PC.
- start_pc  out  D  start address of the current run.
- busy  out  1  high in LOAD and RUN.
- done  out  1  run complete; level signal.
- timeout  out  1  last run ended by the watchdog.
- req_drop  out  1  one-cycle pulse when a request is discarded.
- cycle_cnt  out  CW  RUN cycles of the current or last run.
- run_idx  out  PW  slot of the current or last run.

Behaviour:
- Reset (reset=0, async):
  - State=IDLE.
  - core_rst=1; pc_load=0; busy=0; done=0; timeout=0; req_drop=0.
  - cycle_cnt=0; run_idx=0; start_pc=0; pending slot empty.
  - Table entry i = i*(2^D/NPROG).
- FSM states: IDLE, LOAD, RUN, DONE.
  - IDLE: core_rst=1. On req with prog_sel<NPROG: latch run_idx=prog_sel and start_pc=table[prog_sel]; next state LOAD.
  - LOAD (exactly 1 cycle): core_rst=1, pc_load=1, busy=1, cycle_cnt cleared to 0, done=0, timeout=0. Next state RUN.
  - RUN:
    - core_rst=0, busy=1; cycle_cnt increments each cycle, saturating at all-ones.
    - halt=1: go to DONE with timeout=0. cycle_cnt includes the halt cycle and then freezes.
    - Else if tmo_limit!=0 and the incremented cycle_cnt equals tmo_limit: go to DONE with timeout=1.
  - DONE:
    - core_rst=1, done=1, busy=0; done, timeout and cycle_cnt hold.
    - If pending is occupied: stay exactly 1 cycle, load run_idx/start_pc from pending, clear pending, go to LOAD.
    - Else stay until req, then behave as IDLE acceptance.
- Request rules:
  - req with prog_sel>=NPROG in any state: ignored, req_drop pulses the next cycle.
  - req in LOAD or RUN: stored in the one-deep pending slot (prog_sel plus the table entry read at that moment).
  - req in LOAD or RUN with pending already full: dropped, req_drop pulses, the original pending entry is kept.
  - req held high continuously is accepted once per acceptance opportunity; there is no edge detection.
- Simultaneous events:
  - halt and watchdog match in the same cycle: halt wins, timeout=0.
  - cfg_we to the slot of the current run does not affect start_pc; the latch happens at acceptance.
  - cfg_we and acceptance of the same slot in the same cycle: acceptance reads the old value; the write takes effect after.
- halt outside RUN is ignored.
- reset deasserted mid-run returns to IDLE; the pending slot is lost.

Decomposition:
- Package run_pkg:
  - state_t enum {IDLE, LOAD, RUN, DONE}.
  - Function default_start(i, D, NPROG).
- Sub-module start_table: NPROG x D register array.
  - Async-reset defaults, synchronous cfg write port, combinational read port for prog_sel.

Test Plan:
- Reset, req=1 with prog_sel=1 for one cycle, halt after 5 RUN cycles -> pc_load pulses once with start_pc=256; done=1; cycle_cnt=5; timeout=0; core_rst=1 in DONE.
- tmo_limit=8, halt never asserted -> DONE after 8 RUN cycles, timeout=1, cycle_cnt=8. Then halt and a count of 3 arriving together with tmo_limit=3 -> timeout=0.
- req for slot 2 during RUN, then req for slot 3 during the same RUN -> req_drop pulses once for slot 3. After halt: DONE lasts 1 cycle, then LOAD with run_idx=2, start_pc=512.
- cfg_we idx=0 addr=0x3F5, then req for slot 0 -> start_pc=0x3F5. A cfg write to slot 0 during that run leaves start_pc unchanged.
- NPROG=3, req with prog_sel=3 -> req_drop=1, state stays IDLE. Reset asserted mid-RUN -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/run_pkg.sv
// Shared types and helpers for the run controller.
//   state_t       : controller FSM states
//   default_start : reset value of start-table entry i (evenly spaced over the PC space)
package run_pkg;

  // StIdle/StLoad/StRun/StDone map to the IDLE/LOAD/RUN/DONE controller states.
  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_t;

  function automatic int unsigned default_start(input int unsigned i, input int unsigned d,
                                                input int unsigned nprog);
    return i * ((32'd1 << d) / nprog);
  endfunction

endpackage

// File: rtl/run_ctrl_if.sv
// Host/core-facing bundle of the run controller.
//   master : host side (drives req/prog_sel/tmo_limit/cfg_*, forwards core halt)
//   slave  : controller side (drives core_rst/pc_load/start_pc and status)
interface run_ctrl_if #(
  parameter int unsigned D     = 10,
  parameter int unsigned NPROG = 4,
  parameter int unsigned CW    = 16,
  parameter int unsigned PW    = $clog2(NPROG)
);
  logic          req;
  logic [PW-1:0] prog_sel;
  logic [CW-1:0] tmo_limit;
  logic          cfg_we;
  logic [PW-1:0] cfg_idx;
  logic [D-1:0]  cfg_addr;
  logic          halt;
  logic          core_rst;
  logic          pc_load;
  logic [D-1:0]  start_pc;
  logic          busy;
  logic          done;
  logic          timeout;
  logic          req_drop;
  logic [CW-1:0] cycle_cnt;
  logic [PW-1:0] run_idx;

  modport master (
    output req, prog_sel, tmo_limit, cfg_we, cfg_idx, cfg_addr, halt,
    input  core_rst, pc_load, start_pc, busy, done, timeout, req_drop, cycle_cnt, run_idx
  );

  modport slave (
    input  req, prog_sel, tmo_limit, cfg_we, cfg_idx, cfg_addr, halt,
    output core_rst, pc_load, start_pc, busy, done, timeout, req_drop, cycle_cnt, run_idx
  );
endinterface

// File: rtl/start_table.sv
// Per-program start-PC table: NPROG x D registers.
//   i_clk, i_reset : clock, async active-low reset (entries return to default_start values)
//   i_we/i_widx/i_wdata : synchronous write port; out-of-range index ignored
//   i_ridx/o_rdata      : combinational read port; out-of-range index reads 0
module start_table
  import run_pkg::*;
#(
  parameter int unsigned D     = 10,
  parameter int unsigned NPROG = 4,
  parameter int unsigned PW    = $clog2(NPROG)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_we,
  input  logic [PW-1:0] i_widx,
  input  logic [D-1:0]  i_wdata,
  input  logic [PW-1:0] i_ridx,
  output logic [D-1:0]  o_rdata
);

  localparam logic [PW:0] NPROG_L = (PW+1)'(NPROG);

  logic [D-1:0] r_tab [NPROG];
  logic         w_wr_ok;
  logic         w_rd_ok;

  assign w_wr_ok = i_we && ({1'b0, i_widx} < NPROG_L);
  assign w_rd_ok = {1'b0, i_ridx} < NPROG_L;
  assign o_rdata = w_rd_ok ? r_tab[i_ridx] : '0;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int unsigned i = 0; i < NPROG; i++) begin
        r_tab[i] <= D'(default_start(i, D, NPROG));
      end
    end else if (w_wr_ok) begin
      r_tab[i_widx] <= i_wdata;
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Run controller wrapping the CPU core: holds the core in reset between runs, loads a
// per-program start PC, counts RUN cycles, enforces a watchdog and queues one request.
//   i_clk   : clock
//   i_reset : async active-low reset
//   io_bus  : run_ctrl_if.slave (req/prog_sel/tmo_limit/cfg_*/halt in;
//             core_rst/pc_load/start_pc/busy/done/timeout/req_drop/cycle_cnt/run_idx out)
module run_ctrl
  import run_pkg::*;
#(
  parameter int unsigned D     = 10,
  parameter int unsigned NPROG = 4,
  parameter int unsigned CW    = 16,
  parameter int unsigned PW    = $clog2(NPROG)
) (
  input  logic        i_clk,
  input  logic        i_reset,
  run_ctrl_if.slave   io_bus
);

  localparam logic [PW:0] NPROG_L = (PW+1)'(NPROG);

  state_t        r_state, w_state_d;
  logic [PW-1:0] r_run_idx, w_run_idx_d;
  logic [D-1:0]  r_start_pc, w_start_pc_d;
  logic [CW-1:0] r_cnt, w_cnt_d;
  logic          r_timeout, w_timeout_d;
  logic          r_req_drop, w_req_drop_d;
  logic          r_pend_vld, w_pend_vld_d;
  logic [PW-1:0] r_pend_idx, w_pend_idx_d;
  logic [D-1:0]  r_pend_pc, w_pend_pc_d;

  logic          w_sel_ok;
  logic          w_req_ok;
  logic [D-1:0]  w_tab_rd;
  logic [CW-1:0] w_cnt_inc;

  start_table #(
    .D     (D),
    .NPROG (NPROG),
    .PW    (PW)
  ) u_start_table (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_we    (io_bus.cfg_we),
    .i_widx  (io_bus.cfg_idx),
    .i_wdata (io_bus.cfg_addr),
    .i_ridx  (io_bus.prog_sel),
    .o_rdata (w_tab_rd)
  );

  assign w_sel_ok  = {1'b0, io_bus.prog_sel} < NPROG_L;
  assign w_req_ok  = io_bus.req & w_sel_ok;
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_state_d    = r_state;
    w_run_idx_d  = r_run_idx;
    w_start_pc_d = r_start_pc;
    w_cnt_d      = r_cnt;
    w_timeout_d  = r_timeout;
    w_pend_vld_d = r_pend_vld;
    w_pend_idx_d = r_pend_idx;
    w_pend_pc_d  = r_pend_pc;
    // Out-of-range slot requests are discarded in every state.
    w_req_drop_d = io_bus.req & ~w_sel_ok;

    unique case (r_state)
      StIdle: begin
        if (w_req_ok) begin
          w_state_d    = StLoad;
          w_run_idx_d  = io_bus.prog_sel;
          w_start_pc_d = w_tab_rd;
          w_cnt_d      = '0;
          w_timeout_d  = 1'b0;
        end
      end
      StLoad, StRun: begin
        if (w_req_ok) begin
          if (r_pend_vld) begin
            w_req_drop_d = 1'b1;
          end else begin
            // Table is read now, so later cfg writes do not alter the queued run.
            w_pend_vld_d = 1'b1;
            w_pend_idx_d = io_bus.prog_sel;
            w_pend_pc_d  = w_tab_rd;
          end
        end
        if (r_state == StLoad) begin
          w_state_d = StRun;
        end else begin
          w_cnt_d = w_cnt_inc;
          // Halt has priority over a watchdog match in the same cycle.
          if (io_bus.halt) begin
            w_state_d   = StDone;
            w_timeout_d = 1'b0;
          end else if ((io_bus.tmo_limit != '0) && (w_cnt_inc == io_bus.tmo_limit)) begin
            w_state_d   = StDone;
            w_timeout_d = 1'b1;
          end
        end
      end
      StDone: begin
        if (r_pend_vld) begin
          w_state_d    = StLoad;
          w_run_idx_d  = r_pend_idx;
          w_start_pc_d = r_pend_pc;
          w_pend_vld_d = 1'b0;
          w_cnt_d      = '0;
          w_timeout_d  = 1'b0;
          // This cycle's acceptance slot is taken by the queued run.
          if (w_req_ok) w_req_drop_d = 1'b1;
        end else if (w_req_ok) begin
          w_state_d    = StLoad;
          w_run_idx_d  = io_bus.prog_sel;
          w_start_pc_d = w_tab_rd;
          w_cnt_d      = '0;
          w_timeout_d  = 1'b0;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= StIdle;
      r_run_idx  <= '0;
      r_start_pc <= '0;
      r_cnt      <= '0;
      r_timeout  <= 1'b0;
      r_req_drop <= 1'b0;
      r_pend_vld <= 1'b0;
      r_pend_idx <= '0;
      r_pend_pc  <= '0;
    end else begin
      r_state    <= w_state_d;
      r_run_idx  <= w_run_idx_d;
      r_start_pc <= w_start_pc_d;
      r_cnt      <= w_cnt_d;
      r_timeout  <= w_timeout_d;
      r_req_drop <= w_req_drop_d;
      r_pend_vld <= w_pend_vld_d;
      r_pend_idx <= w_pend_idx_d;
      r_pend_pc  <= w_pend_pc_d;
    end
  end

  assign io_bus.core_rst  = (r_state != StRun);
  assign io_bus.pc_load   = (r_state == StLoad);
  assign io_bus.busy      = (r_state == StLoad) || (r_state == StRun);
  assign io_bus.done      = (r_state == StDone);
  assign io_bus.timeout   = r_timeout;
  assign io_bus.req_drop  = r_req_drop;
  assign io_bus.cycle_cnt = r_cnt;
  assign io_bus.run_idx   = r_run_idx;
  assign io_bus.start_pc  = r_start_pc;

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: a cycle-by-cycle vector table for the basic run and
// queued-request flow, plus directed sequences for watchdog, cfg timing, NPROG=3 and
// asynchronous reset.
module tb_run_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  run_ctrl_if #(.D(10), .NPROG(4), .CW(16)) bus ();
  run_ctrl_if #(.D(10), .NPROG(3), .CW(16)) bus3 ();

  run_ctrl #(.D(10), .NPROG(4), .CW(16)) u_dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .io_bus  (bus)
  );

  run_ctrl #(.D(10), .NPROG(3), .CW(16)) u_dut3 (
    .i_clk   (clk),
    .i_reset (rst_n),
    .io_bus  (bus3)
  );

  typedef struct {
    logic        req;
    logic [1:0]  sel;
    logic        halt;
    logic [33:0] exp;
  } vec_t;

  vec_t vecs[$];

  // {core_rst, pc_load, busy, done, timeout, req_drop, cycle_cnt, run_idx, start_pc}
  function automatic logic [33:0] pk(input logic cr, input logic pl, input logic bz,
                                     input logic dn, input logic to, input logic dr,
                                     input logic [15:0] cnt, input logic [1:0] idx,
                                     input logic [9:0] pc);
    return {cr, pl, bz, dn, to, dr, cnt, idx, pc};
  endfunction

  function automatic logic [33:0] act();
    return {bus.core_rst, bus.pc_load, bus.busy, bus.done, bus.timeout, bus.req_drop,
            bus.cycle_cnt, bus.run_idx, bus.start_pc};
  endfunction

  function automatic logic [33:0] act3();
    return {bus3.core_rst, bus3.pc_load, bus3.busy, bus3.done, bus3.timeout, bus3.req_drop,
            bus3.cycle_cnt, bus3.run_idx, bus3.start_pc};
  endfunction

  task automatic add(input logic req, input logic [1:0] sel, input logic halt,
                     input logic [33:0] exp);
    vec_t v;
    v.req = req; v.sel = sel; v.halt = halt; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [33:0] RST_VAL = {1'b1, 5'b0, 16'd0, 2'd0, 10'd0};

  initial begin
    #2000000;
    $display("FAIL sim_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int n;
    bus.req = 0; bus.prog_sel = 0; bus.tmo_limit = 0; bus.cfg_we = 0;
    bus.cfg_idx = 0; bus.cfg_addr = 0; bus.halt = 0;
    bus3.req = 0; bus3.prog_sel = 0; bus3.tmo_limit = 0; bus3.cfg_we = 0;
    bus3.cfg_idx = 0; bus3.cfg_addr = 0; bus3.halt = 0;

    // Basic run: slot 1, halt in the 5th RUN cycle (halt in DONE is ignored).
    add(1, 1, 0, pk(1, 1, 1, 0, 0, 0, 0, 1, 10'd256));
    add(0, 0, 0, pk(0, 0, 1, 0, 0, 0, 0, 1, 10'd256));
    add(0, 0, 0, pk(0, 0, 1, 0, 0, 0, 1, 1, 10'd256));
    add(0, 0, 0, pk(0, 0, 1, 0, 0, 0, 2, 1, 10'd256));
    add(0, 0, 0, pk(0, 0, 1, 0, 0, 0, 3, 1, 10'd256));
    add(0, 0, 0, pk(0, 0, 1, 0, 0, 0, 4, 1, 10'd256));
    add(0, 0, 1, pk(1, 0, 0, 1, 0, 0, 5, 1, 10'd256));
    add(0, 0, 1, pk(1, 0, 0, 1, 0, 0, 5, 1, 10'd256));
    // Slot 0 run; queue slot 2, slot 3 dropped, then queued run starts after 1 DONE cycle.
    add(1, 0, 0, pk(1, 1, 1, 0, 0, 0, 0, 0, 10'd0));
    add(0, 0, 0, pk(0, 0, 1, 0, 0, 0, 0, 0, 10'd0));
    add(1, 2, 0, pk(0, 0, 1, 0, 0, 0, 1, 0, 10'd0));
    add(1, 3, 0, pk(0, 0, 1, 0, 0, 1, 2, 0, 10'd0));
    add(0, 0, 0, pk(0, 0, 1, 0, 0, 0, 3, 0, 10'd0));
    add(0, 0, 1, pk(1, 0, 0, 1, 0, 0, 4, 0, 10'd0));
    add(0, 0, 0, pk(1, 1, 1, 0, 0, 0, 0, 2, 10'd512));
    add(0, 0, 0, pk(0, 0, 1, 0, 0, 0, 0, 2, 10'd512));
    add(0, 0, 1, pk(1, 0, 0, 1, 0, 0, 1, 2, 10'd512));
    add(0, 0, 0, pk(1, 0, 0, 1, 0, 0, 1, 2, 10'd512));

    #12;
    check("reset_state", 64'(act()), 64'(RST_VAL));
    check("reset_state3", 64'(act3()), 64'(RST_VAL));
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      bus.req = vecs[i].req; bus.prog_sel = vecs[i].sel; bus.halt = vecs[i].halt;
      tick();
      check($sformatf("vec%0d", i), 64'(act()), 64'(vecs[i].exp));
    end
    bus.req = 0; bus.halt = 0;

    // Watchdog: tmo_limit=8, no halt.
    bus.tmo_limit = 16'd8; bus.req = 1; bus.prog_sel = 3;
    tick();
    bus.req = 0;
    check("wdog_load", 64'(act()), 64'(pk(1, 1, 1, 0, 0, 0, 0, 3, 10'd768)));
    tick();
    n = 0;
    while (!bus.done && n < 20) begin
      tick();
      n++;
    end
    check("wdog_cycles", 64'(n), 64'd8);
    check("wdog_done", 64'(act()), 64'(pk(1, 0, 0, 1, 1, 0, 8, 3, 10'd768)));

    // Halt and watchdog match together: halt wins.
    bus.tmo_limit = 16'd3; bus.req = 1; bus.prog_sel = 1;
    tick();
    bus.req = 0;
    check("coinc_load", 64'(act()), 64'(pk(1, 1, 1, 0, 0, 0, 0, 1, 10'd256)));
    tick(); tick(); tick();
    bus.halt = 1;
    tick();
    bus.halt = 0;
    check("coinc_done", 64'(act()), 64'(pk(1, 0, 0, 1, 0, 0, 3, 1, 10'd256)));
    bus.tmo_limit = 16'd0;

    // cfg write then run from that slot; write during the run does not move start_pc.
    bus.cfg_we = 1; bus.cfg_idx = 0; bus.cfg_addr = 10'h3F5;
    tick();
    bus.cfg_we = 0; bus.req = 1; bus.prog_sel = 0;
    tick();
    bus.req = 0;
    check("cfg_load_pc", 64'(bus.start_pc), 64'h3F5);
    bus.cfg_we = 1; bus.cfg_idx = 0; bus.cfg_addr = 10'h0AA;
    tick();
    bus.cfg_we = 0;
    check("cfg_run_pc", 64'(bus.start_pc), 64'h3F5);
    bus.halt = 1;
    tick();
    bus.halt = 0;
    // Write and acceptance of the same slot in one cycle: old value is used.
    bus.cfg_we = 1; bus.cfg_idx = 1; bus.cfg_addr = 10'h111; bus.req = 1; bus.prog_sel = 1;
    tick();
    bus.cfg_we = 0; bus.req = 0;
    check("cfg_same_cycle_pc", 64'(bus.start_pc), 64'd256);
    tick();
    bus.halt = 1;
    tick();
    bus.halt = 0;
    bus.req = 1; bus.prog_sel = 1;
    tick();
    bus.req = 0;
    check("cfg_after_pc", 64'(bus.start_pc), 64'h111);
    tick();
    bus.halt = 1;
    tick();
    bus.halt = 0;

    // NPROG=3: slot 3 is out of range.
    bus3.req = 1; bus3.prog_sel = 3;
    tick();
    bus3.req = 0;
    check("np3_drop", 64'(act3()), 64'({1'b1, 4'b0, 1'b1, 16'd0, 2'd0, 10'd0}));
    tick();
    check("np3_idle", 64'(act3()), 64'(RST_VAL));
    bus3.req = 1; bus3.prog_sel = 2;
    tick();
    bus3.req = 0;
    check("np3_slot2", 64'(act3()), 64'(pk(1, 1, 1, 0, 0, 0, 0, 2, 10'd682)));

    // Async reset mid-RUN with a pending request queued.
    bus.req = 1; bus.prog_sel = 2;
    tick();
    bus.prog_sel = 1;
    tick();
    bus.req = 0;
    tick();
    check("pre_reset_run", 64'(act()), 64'(pk(0, 0, 1, 0, 0, 0, 1, 2, 10'd512)));
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", 64'(act()), 64'(RST_VAL));
    #2 rst_n = 1'b1;
    tick();
    check("pending_lost", 64'(act()), 64'(RST_VAL));
    bus.req = 1; bus.prog_sel = 0;
    tick();
    bus.req = 0;
    check("table_reset", 64'(act()), 64'(pk(1, 1, 1, 0, 0, 0, 0, 0, 10'd0)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
